// File: rtl/laser_pkg.sv
// rtl/laser_pkg.sv - shared types and default sizes for the laser sweep scheduler
package laser_pkg;

  localparam int COORD_W_DEF   = 4;
  localparam int CNT_W_DEF     = 6;
  localparam int NUM_PTS_DEF   = 40;
  localparam int MAX_PAIRS_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_UPDATE,
    S_PASS_END,
    S_FINISH
  } state_t;

  typedef enum logic {
    MOVE_C1 = 1'b0,
    MOVE_C2 = 1'b1
  } mover_t;

endpackage

// File: rtl/laser_sweep_sched_if.sv
// rtl/laser_sweep_sched_if.sv - candidate evaluation req/ack channel to the coverage-count datapath
interface laser_sweep_sched_if #(
  parameter int COORD_W = 4,
  parameter int CNT_W   = 6
);
  logic               EVAL_REQ;
  logic               EVAL_ACK;
  logic [CNT_W-1:0]   EVAL_CNT;
  logic [COORD_W-1:0] CAND_X;
  logic [COORD_W-1:0] CAND_Y;
  logic [COORD_W-1:0] FIX_X;
  logic [COORD_W-1:0] FIX_Y;

  modport master (
    output EVAL_REQ, CAND_X, CAND_Y, FIX_X, FIX_Y,
    input  EVAL_ACK, EVAL_CNT
  );

  modport slave (
    input  EVAL_REQ, CAND_X, CAND_Y, FIX_X, FIX_Y,
    output EVAL_ACK, EVAL_CNT
  );
endinterface

// File: rtl/laser_raster_cnt.sv
// rtl/laser_raster_cnt.sv - 2-D raster counter, X inner and Y outer, with last flag at (max,max)
module laser_raster_cnt #(
  parameter int COORD_W = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               clear_i,
  input  logic               adv_i,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               last_o
);
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;

  // next raster position: clear wins, Y steps when X wraps
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear_i) begin
      x_d = '0;
      y_d = '0;
    end else if (adv_i) begin
      x_d = x_q + 1'b1;
      if (&x_q) y_d = y_q + 1'b1;
    end
  end

  // position registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = (&x_q) & (&y_q);
endmodule

// File: rtl/laser_sweep_sched.sv
// rtl/laser_sweep_sched.sv - alternating circle sweep scheduler; LASER_EARLY_EXIT_EN enables finish on full coverage
module laser_sweep_sched
  import laser_pkg::*;
#(
  parameter int COORD_W   = COORD_W_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int NUM_PTS   = NUM_PTS_DEF,
  parameter int MAX_PAIRS = MAX_PAIRS_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic [COORD_W-1:0] SEED_X,
  input  logic [COORD_W-1:0] SEED_Y,
  laser_sweep_sched_if.master ev,
  output logic [COORD_W-1:0] C1X,
  output logic [COORD_W-1:0] C1Y,
  output logic [COORD_W-1:0] C2X,
  output logic [COORD_W-1:0] C2Y,
  output logic               DONE
);
  localparam int PAIR_W = $clog2(MAX_PAIRS + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_PTS);

  state_t             state_q, state_d;
  mover_t             mover_q, mover_d;
  logic [COORD_W-1:0] c1x_q, c1x_d, c1y_q, c1y_d;
  logic [COORD_W-1:0] c2x_q, c2x_d, c2y_q, c2y_d;
  logic [CNT_W-1:0]   best_q, best_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PAIR_W-1:0]  pair_q, pair_d;
  logic               improved_q, improved_d;
  logic               done_q;

  logic               rs_clr, rs_adv, rs_last;
  logic [COORD_W-1:0] rs_x, rs_y;
  logic               early_exit;

`ifdef LASER_EARLY_EXIT_EN
  assign early_exit = (cnt_q == FULL_CNT);
`else
  // full coverage is an ordinary improvement in this build
  logic unused_full_cnt;
  assign early_exit      = 1'b0;
  assign unused_full_cnt = ^FULL_CNT;
`endif

  laser_raster_cnt #(.COORD_W(COORD_W)) u_raster (
    .CLK     (CLK),
    .RST     (RST),
    .clear_i (rs_clr),
    .adv_i   (rs_adv),
    .x_o     (rs_x),
    .y_o     (rs_y),
    .last_o  (rs_last)
  );

  // next-state and datapath updates for the sweep FSM
  always_comb begin
    state_d    = state_q;
    mover_d    = mover_q;
    c1x_d      = c1x_q;
    c1y_d      = c1y_q;
    c2x_d      = c2x_q;
    c2y_d      = c2y_q;
    best_d     = best_q;
    cnt_d      = cnt_q;
    pair_d     = pair_q;
    improved_d = improved_q;
    rs_clr     = 1'b0;
    rs_adv     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          c1x_d      = '0;
          c1y_d      = '0;
          c2x_d      = SEED_X;
          c2y_d      = SEED_Y;
          best_d     = '0;
          pair_d     = '0;
          mover_d    = MOVE_C1;
          improved_d = 1'b0;
          rs_clr     = 1'b1;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ev.EVAL_ACK) begin
          cnt_d   = ev.EVAL_CNT;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        // strict compare keeps the first candidate on ties
        if (cnt_q > best_q) begin
          best_d     = cnt_q;
          improved_d = 1'b1;
          if (mover_q == MOVE_C1) begin
            c1x_d = rs_x;
            c1y_d = rs_y;
          end else begin
            c2x_d = rs_x;
            c2y_d = rs_y;
          end
        end
        if (early_exit) begin
          state_d = S_FINISH;
        end else if (rs_last) begin
          state_d = S_PASS_END;
        end else begin
          rs_adv  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_PASS_END: begin
        rs_clr = 1'b1;
        if (mover_q == MOVE_C1) begin
          mover_d = MOVE_C2;
          state_d = S_WAIT;
        end else begin
          pair_d = pair_q + 1'b1;
          if (!improved_q || (int'(pair_q) + 1 == MAX_PAIRS)) begin
            state_d = S_FINISH;
          end else begin
            improved_d = 1'b0;
            mover_d    = MOVE_C1;
            state_d    = S_WAIT;
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // state and search registers; DONE registered one cycle behind FINISH
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      mover_q    <= MOVE_C1;
      c1x_q      <= '0;
      c1y_q      <= '0;
      c2x_q      <= '0;
      c2y_q      <= '0;
      best_q     <= '0;
      cnt_q      <= '0;
      pair_q     <= '0;
      improved_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mover_q    <= mover_d;
      c1x_q      <= c1x_d;
      c1y_q      <= c1y_d;
      c2x_q      <= c2x_d;
      c2y_q      <= c2y_d;
      best_q     <= best_d;
      cnt_q      <= cnt_d;
      pair_q     <= pair_d;
      improved_q <= improved_d;
      done_q     <= (state_q == S_FINISH);
    end
  end

  // FIX reads the stationary circle register directly so improvements show at once
  assign ev.EVAL_REQ = (state_q == S_WAIT);
  assign ev.CAND_X   = rs_x;
  assign ev.CAND_Y   = rs_y;
  assign ev.FIX_X    = (mover_q == MOVE_C1) ? c2x_q : c1x_q;
  assign ev.FIX_Y    = (mover_q == MOVE_C1) ? c2y_q : c1y_q;
  assign C1X         = c1x_q;
  assign C1Y         = c1y_q;
  assign C2X         = c2x_q;
  assign C2Y         = c2y_q;
  assign DONE        = done_q;
endmodule

// File: tb/tb_laser_sweep_sched.sv
// tb/tb_laser_sweep_sched.sv - self-checking bench for laser_sweep_sched
module tb_laser_sweep_sched;
  localparam int CW = 4;
  localparam int NW = 6;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          START = 1'b0;
  logic [CW-1:0] SEED_X = '0;
  logic [CW-1:0] SEED_Y = '0;
  logic [CW-1:0] C1X, C1Y, C2X, C2Y;
  logic          DONE;

  laser_sweep_sched_if #(.COORD_W(CW), .CNT_W(NW)) ev ();

  laser_sweep_sched #(.COORD_W(CW), .CNT_W(NW), .NUM_PTS(40), .MAX_PAIRS(4)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .START  (START),
    .SEED_X (SEED_X),
    .SEED_Y (SEED_Y),
    .ev     (ev),
    .C1X    (C1X),
    .C1Y    (C1Y),
    .C2X    (C2X),
    .C2Y    (C2Y),
    .DONE   (DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string         name;
    int            mode;
    int            delay;
    logic [CW-1:0] sx, sy;
    logic [CW-1:0] c1x, c1y, c2x, c2y;
    int            cycles;
  } vec_t;

  typedef struct {
    logic [CW-1:0] c1x, c1y, c2x, c2y;
    int            cycles;
  } exp_t;

  vec_t tbl [5];
  exp_t sbq [$];

  int checks = 0;
  int failures = 0;

  int mode = 4, ack_delay = 0, stall_cnt = 0, pass_idx = 0, ack_n = 0;
  int cyc = 0, done_n = 0, done_cyc = -1, stab_err = 0;
  bit resp_en = 0, idle_pulse = 0, req_seen = 0, fix_p1_seen = 0;
  logic [CW-1:0] fix_p1x = '0, fix_p1y = '0;
  logic [CW-1:0] pcx = '0, pcy = '0, pfx = '0, pfy = '0;
  logic preq = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic logic [NW-1:0] model(input int m, input int p, input logic [CW-1:0] x, input logic [CW-1:0] y);
    logic [NW-1:0] r;
    r = '0;
    case (m)
      0: begin
        if (p % 2 == 0 && x == 4'd3 && y == 4'd7) r = 6'd10;
        else if (p % 2 == 1 && x == 4'd9 && y == 4'd2) r = 6'd12;
      end
      1: if (p % 2 == 0 && ((x == 4'd2 && y == 4'd2) || (x == 4'd5 && y == 4'd5))) r = 6'd8;
      2: if (p == 0 && x == 4'd1 && y == 4'd0) r = 6'd40;
      3: if (int'(x) == p && y == 4'd0) r = 6'(p + 1);
      default: r = '0;
    endcase
    return r;
  endfunction

  // datapath responder, cycle counter, DONE and stability monitor
  initial begin
    ev.EVAL_ACK = 1'b0;
    ev.EVAL_CNT = '0;
    forever begin
      @(negedge CLK);
      if (req_seen) cyc++;
      else if (ev.EVAL_REQ) begin req_seen = 1; cyc = 0; end
      if (DONE) begin done_n++; done_cyc = cyc; end
      if (preq && ev.EVAL_REQ &&
          (ev.CAND_X !== pcx || ev.CAND_Y !== pcy || ev.FIX_X !== pfx || ev.FIX_Y !== pfy))
        stab_err++;
      preq = ev.EVAL_REQ;
      pcx = ev.CAND_X; pcy = ev.CAND_Y; pfx = ev.FIX_X; pfy = ev.FIX_Y;
      if (resp_en && ev.EVAL_REQ) begin
        if (stall_cnt >= ack_delay) begin
          ev.EVAL_ACK = 1'b1;
          ev.EVAL_CNT = model(mode, pass_idx, ev.CAND_X, ev.CAND_Y);
          stall_cnt = 0;
          ack_n++;
          if (pass_idx == 1 && ev.CAND_X == 4'd0 && ev.CAND_Y == 4'd0) begin
            fix_p1_seen = 1; fix_p1x = ev.FIX_X; fix_p1y = ev.FIX_Y;
          end
          if (ev.CAND_X == 4'd15 && ev.CAND_Y == 4'd15) pass_idx++;
        end else begin
          ev.EVAL_ACK = 1'b0;
          ev.EVAL_CNT = '0;
          stall_cnt++;
        end
      end else begin
        ev.EVAL_ACK = idle_pulse ? ~ev.EVAL_ACK : 1'b0;
        ev.EVAL_CNT = idle_pulse ? 6'd40 : 6'd0;
        stall_cnt = 0;
      end
    end
  end

  task automatic run_scn(input int i);
    exp_t e;
    int t;
    mode = tbl[i].mode; ack_delay = tbl[i].delay;
    pass_idx = 0; stall_cnt = 0; req_seen = 0; cyc = 0; done_n = 0; done_cyc = -1;
    stab_err = 0; fix_p1_seen = 0; resp_en = 1;
    SEED_X = tbl[i].sx; SEED_Y = tbl[i].sy;
    e.c1x = tbl[i].c1x; e.c1y = tbl[i].c1y; e.c2x = tbl[i].c2x; e.c2y = tbl[i].c2y;
    e.cycles = tbl[i].cycles;
    sbq.push_back(e);
    @(negedge CLK); START = 1'b1;
    @(negedge CLK); START = 1'b0;
    t = 0;
    while (done_n == 0 && t < 20000) begin @(negedge CLK); t++; end
    repeat (5) @(negedge CLK);
    chk({tbl[i].name, "_done_once"}, 32'(done_n), 32'd1);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({tbl[i].name, "_c1x"}, 32'(C1X), 32'(e.c1x));
      chk({tbl[i].name, "_c1y"}, 32'(C1Y), 32'(e.c1y));
      chk({tbl[i].name, "_c2x"}, 32'(C2X), 32'(e.c2x));
      chk({tbl[i].name, "_c2y"}, 32'(C2Y), 32'(e.c2y));
      chk({tbl[i].name, "_done_cycle"}, 32'(done_cyc), 32'(e.cycles));
    end
    chk({tbl[i].name, "_req_stable"}, 32'(stab_err), 32'd0);
    chk({tbl[i].name, "_req_idle"}, 32'(ev.EVAL_REQ), 32'd0);
    if (mode == 0 && tbl[i].cycles > 5) begin
      chk({tbl[i].name, "_fix_seen"}, 32'(fix_p1_seen), 32'd1);
      chk({tbl[i].name, "_fix_x"}, 32'(fix_p1x), 32'd3);
      chk({tbl[i].name, "_fix_y"}, 32'(fix_p1y), 32'd7);
    end
    resp_en = 0;
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_req"},  32'(ev.EVAL_REQ), 32'd0);
    chk({pfx, "_done"}, 32'(DONE), 32'd0);
    chk({pfx, "_cand"}, 32'({ev.CAND_X, ev.CAND_Y}), 32'd0);
    chk({pfx, "_fix"},  32'({ev.FIX_X, ev.FIX_Y}), 32'd0);
    chk({pfx, "_c1"},   32'({C1X, C1Y}), 32'd0);
    chk({pfx, "_c2"},   32'({C2X, C2Y}), 32'd0);
  endtask

  initial begin
    int t;
    tbl[0] = '{"single", 0, 0, 4'd8, 4'd8, 4'd3, 4'd7, 4'd9, 4'd2, 4 * 513 + 1};
    tbl[1] = '{"tie",    1, 0, 4'd8, 4'd8, 4'd2, 4'd2, 4'd8, 4'd8, 4 * 513 + 1};
`ifdef LASER_EARLY_EXIT_EN
    tbl[2] = '{"early",  2, 0, 4'd4, 4'd9, 4'd1, 4'd0, 4'd4, 4'd9, 5};
`else
    tbl[2] = '{"early",  2, 0, 4'd4, 4'd9, 4'd1, 4'd0, 4'd4, 4'd9, 4 * 513 + 1};
`endif
    tbl[3] = '{"cap",    3, 0, 4'd8, 4'd8, 4'd6, 4'd0, 4'd7, 4'd0, 8 * 513 + 1};
    tbl[4] = '{"stall",  0, 3, 4'd8, 4'd8, 4'd3, 4'd7, 4'd9, 4'd2, 4 * (256 * 5 + 1) + 1};

    repeat (2) @(negedge CLK);
    chk_zero("reset");
    RST = 1'b0;

    idle_pulse = 1; req_seen = 0; done_n = 0;
    repeat (12) @(negedge CLK);
    idle_pulse = 0;
    chk("idle_no_req", 32'(req_seen), 32'd0);
    chk("idle_no_done", 32'(done_n), 32'd0);
    chk_zero("idle");

    for (int i = 0; i < 5; i++) run_scn(i);

    mode = 0; ack_delay = 0; pass_idx = 0; ack_n = 0; done_n = 0; resp_en = 1;
    SEED_X = 4'd8; SEED_Y = 4'd8;
    @(negedge CLK); START = 1'b1;
    @(negedge CLK); START = 1'b0;
    t = 0;
    while (ack_n < 100 && t < 1000) begin @(negedge CLK); t++; end
    chk("midrst_reached", 32'(ack_n >= 100), 32'd1);
    #2 RST = 1'b1;
    #1 chk_zero("midrst");
    resp_en = 0;
    repeat (3) @(negedge CLK);
    chk("midrst_no_done", 32'(done_n), 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    run_scn(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/laser_sweep_sched.md
# laser_sweep_sched

Scheduler for the two-circle laser coverage search. After the point loader has buffered all NUM_PTS points and produced a seed centre, this block alternately fixes one circle and raster-sweeps the other circle over the 16x16 grid. For each candidate it issues a request to the coverage-count datapath over a req/ack handshake and keeps the best centres. When the search converges it publishes C1/C2 and pulses DONE.

## Interface
- COORD_W, 4: coordinate width; grid is 2^COORD_W per axis.
- CNT_W, 6: coverage count width.
- NUM_PTS, 40: total points; the count value treated as full coverage.
- MAX_PAIRS, 4: maximum number of pair-passes (circle 1 sweep plus circle 2 sweep).
- CLK  in  1  clock.
- RST  in  1  reset, asynchronous, active-high.
- START  in  1  one-cycle pulse; begins a search. Ignored unless the block is idle.
- SEED_X, SEED_Y  in  COORD_W  initial circle 2 centre; sampled on START.
- CAND_X, CAND_Y  out  COORD_W  candidate centre for the moving circle.
- FIX_X, FIX_Y  out  COORD_W  current centre of the fixed circle.
- EVAL_REQ  out  1  evaluation request.
- EVAL_ACK  in  1  evaluation done; EVAL_CNT is valid in the same cycle.
- EVAL_CNT  in  CNT_W  number of points covered by the union of the CAND and FIX circles.
- C1X, C1Y, C2X, C2Y  out  COORD_W  best centres found so far.
- DONE  out  1  one-cycle pulse when the search is complete.

## Operation
- States: IDLE, WAIT, UPDATE, PASS_END, FINISH.
- IDLE, START=1:
  - C1 <= (0,0); C2 <= SEED; best_cnt <= 0; pair <= 0; mover <= circle 1.
  - Raster position <= (0,0); improved <= 0.
  - Go to WAIT.
- WAIT:
  - EVAL_REQ=1. CAND is the raster position. FIX is the non-moving circle's register.
  - On EVAL_ACK=1: capture EVAL_CNT, drop EVAL_REQ, go to UPDATE.
- UPDATE:
  - If the captured count > best_cnt (strictly greater): best_cnt <= count, the moving circle's C register <= CAND, improved <= 1.
  - If the raster is at (15,15): go to PASS_END. Otherwise advance the raster (X inner, Y outer, both incrementing) and return to WAIT.
- PASS_END:
  - Raster <= (0,0).
  - If mover was circle 1: mover <= circle 2, go to WAIT.
  - Otherwise pair <= pair+1, then:
    - If improved=0 or pair+1 == MAX_PAIRS: go to FINISH.
    - Else improved <= 0, mover <= circle 1, go to WAIT.
- FINISH: DONE=1 for one cycle, then IDLE. C1/C2 hold their values until the next START or RST.
- The pass using the newly updated circle always reads that register directly, so the FIX outputs reflect improvements immediately.
- Count compare is unsigned CNT_W. Raster X and Y wrap naturally at 2^COORD_W.
- EVAL_ACK outside WAIT is ignored. START while not in IDLE is ignored.

## Timing
- Reset values: all outputs 0, including EVAL_REQ, DONE, CAND, FIX, C1X, C1Y, C2X, C2Y. State is IDLE.
- RST mid-search: the search aborts immediately and all outputs return to their reset values. No DONE pulse.
- START at edge t: EVAL_REQ=1 with CAND=(0,0) and FIX=SEED from t+1.
- CAND and FIX are held stable while EVAL_REQ=1.
- With EVAL_ACK tied high, each candidate takes 2 cycles (WAIT, UPDATE).
  - Each pass adds 1 PASS_END cycle: 513 cycles per pass.
  - DONE asserts 1 cycle after the final PASS_END.
- Outputs are registered. There is no combinational path from EVAL_ACK to EVAL_REQ.

## Configuration
- LASER_EARLY_EXIT_EN defined: in UPDATE, a captured count == NUM_PTS sets the new best and goes directly to FINISH, skipping the remaining candidates and passes.
- LASER_EARLY_EXIT_EN undefined: a full-coverage count is treated like any other improvement, and the sweep continues normally.

## Structure
- laser_pkg holds:
  - state enum;
  - COORD_W, CNT_W, NUM_PTS defaults;
  - mover encoding (MOVE_C1, MOVE_C2).
- Sub-module laser_raster_cnt: 2-D raster counter with clear and advance inputs, X/Y outputs, and a last flag that is high at (max,max).

## Test plan
- Reset, then idle with no START:
  - all outputs stay 0;
  - EVAL_ACK pulses produce no EVAL_REQ.
- Single improvement per circle:
  - Model returns 10 at CAND=(3,7) while mover=C1 and 12 at CAND=(9,2) while mover=C2; every other candidate returns 0. SEED=(8,8).
  - Required: after the first C1 pass, FIX=(3,7) during the C2 pass. Final C1=(3,7), C2=(9,2).
  - Required: the second pair yields no improvement; DONE pulses once, 4×513+1 cycles after the first EVAL_REQ with ACK tied high.
- Tie-break: model returns 8 at (2,2) and (5,5) in the C1 pass, 0 elsewhere. Required: C1=(2,2).
- Early exit: model returns 40 at CAND=(1,0) in the first pass.
  - With LASER_EARLY_EXIT_EN: C1=(1,0); DONE 3 cycles after that ACK.
  - Without it: the full sweep continues, and DONE follows 4 passes.
- Handshake stall and MAX_PAIRS cap:
  - Stall: ACK delayed 3 cycles per request. Required: EVAL_REQ, CAND and FIX stay stable until ACK.
  - Cap: the model improves every pass with MAX_PAIRS=2. Required: DONE after exactly 4 passes.
- RST mid-sweep: assert RST at candidate 100.
  - Required: all outputs are 0 asynchronously.
  - Required: a re-START with the same model reproduces the scenario 2 results.
